// File: rtl/qos_pkg.sv
// ---------------------------------------------------------------------------
// qos_pkg
//
// Shared types and constants for the QoS memory-port arbiter.
//
//   QOS_MAX_REQ   upper bound on the number of cores one arbiter can serve
//   qos_config_t  per-core QoS configuration. The arbiter latches it at grant
//                 time and forwards it to the downstream QoS monitor.
//   arb_state_e   two-state arbiter FSM encoding (IDLE, GRANT)
// ---------------------------------------------------------------------------
package qos_pkg;

    localparam int QOS_MAX_REQ = 8;

    // qos_level: a higher value wins when no requester is urgent.
    // max_latency_cycles: wait budget in cycles. Zero disables the deadline.
    typedef struct packed {
        logic [3:0]  qos_level;
        logic [15:0] max_latency_cycles;
    } qos_config_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/qos_rr_select.sv
// ---------------------------------------------------------------------------
// qos_rr_select
//
// Combinational masked round-robin picker. It returns the first set bit of
// the candidate vector, scanning from ptr_i upward and wrapping modulo
// NUM_REQ.
//
//   cand_i   candidate vector (already filtered by urgency / QoS level)
//   ptr_i    round-robin start index
//   pick_o   chosen index (0 when nothing is found)
//   found_o  at least one candidate bit was set
// ---------------------------------------------------------------------------
module qos_rr_select
    import qos_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] cand_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   pick_o,
    output logic               found_o
);

    logic [IDX_W-1:0] probe;

    // Walk the candidates in rotated order, starting at the pointer. The first
    // hit wins. The modulo handles NUM_REQ values that are not powers of two,
    // where a plain IDX_W-bit wrap would land on non-existent requesters.
    always_comb begin
        pick_o  = '0;
        found_o = 1'b0;
        probe   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found_o && cand_i[probe]) begin
                found_o = 1'b1;
                pick_o  = probe;
            end
        end
    end

endmodule

// File: rtl/qos_arbiter.sv
// ---------------------------------------------------------------------------
// qos_arbiter
//
// Shares one external memory request port between NUM_REQ cores. Priority
// order is: deadline urgency first, then QoS level, then round-robin. The
// arbiter only handles control; the address and data muxes outside the block
// steer on grant_id_o.
//
//   clk_i, rst_i          clock, synchronous active-high reset
//   qos_enable_i          1 = QoS-aware selection, 0 = plain round-robin
//   req_valid_i           per-core request valid
//   req_ready_o           per-core accept (one-hot or zero)
//   req_qos_i             per-core QoS configuration
//   mem_req_valid_o       request valid towards memory
//   mem_req_ready_i       memory accept
//   grant_id_o            index of the current grantee
//   granted_qos_config_o  latched config of the current grantee
//   granted_valid_o       granted_qos_config_o is meaningful
//   deadline_miss_o       saturating count of late handshakes
// ---------------------------------------------------------------------------
module qos_arbiter
    import qos_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WAIT_W  = 16,
    parameter  int CNT_W   = 32,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               qos_enable_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    input  qos_config_t        req_qos_i [NUM_REQ],
    output logic               mem_req_valid_o,
    input  logic               mem_req_ready_i,
    output logic [IDX_W-1:0]   grant_id_o,
    output qos_config_t        granted_qos_config_o,
    output logic               granted_valid_o,
    output logic [CNT_W-1:0]   deadline_miss_o
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rrPtr_q, rrPtr_d;
    logic [IDX_W-1:0]   grantId_q, grantId_d;
    qos_config_t        grantCfg_q, grantCfg_d;
    logic [WAIT_W-1:0]  waitCnt_q [NUM_REQ];
    logic [WAIT_W-1:0]  waitCnt_d [NUM_REQ];
    logic [CNT_W-1:0]   missCnt_q, missCnt_d;

    logic [NUM_REQ-1:0] urgent;
    logic [NUM_REQ-1:0] candidates;
    logic [NUM_REQ-1:0] finalists;
    logic [3:0]         maxLevel;
    logic [IDX_W-1:0]   pickIdx;
    logic               pickFound;
    logic               handshake;
    logic [WAIT_W-1:0]  grantLat;
    logic               lateGrant;

    assign handshake = (state_q == GRANT) && mem_req_ready_i;
    assign grantLat  = WAIT_W'(grantCfg_q.max_latency_cycles);

    // A requester is urgent once it has waited at least its latency budget.
    // A zero budget means "no deadline". Urgency only exists in QoS mode, so
    // with qos_enable_i low the selection falls back to pure round-robin.
    always_comb begin
        urgent = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            urgent[i] = qos_enable_i && req_valid_i[i]
                     && (WAIT_W'(req_qos_i[i].max_latency_cycles) != '0)
                     && (waitCnt_q[i] >= WAIT_W'(req_qos_i[i].max_latency_cycles));
        end
    end

    // Build the set that goes into the round-robin picker. Urgent requesters
    // shadow everyone else. In QoS mode the set is then narrowed to the
    // highest qos_level present, so round-robin only breaks ties between
    // equal levels.
    always_comb begin
        candidates = (|urgent) ? urgent : req_valid_i;
        maxLevel   = '0;
        finalists  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (candidates[i] && (req_qos_i[i].qos_level > maxLevel)) begin
                maxLevel = req_qos_i[i].qos_level;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            finalists[i] = candidates[i]
                        && (!qos_enable_i || (req_qos_i[i].qos_level == maxLevel));
        end
    end

    qos_rr_select #(
        .NUM_REQ (NUM_REQ)
    ) u_rrSelect (
        .cand_i  (finalists),
        .ptr_i   (rrPtr_q),
        .pick_o  (pickIdx),
        .found_o (pickFound)
    );

    // FSM next-state and per-core ready. In IDLE the winner's index and config
    // are latched, so later edits to req_qos_i do not disturb the monitor.
    // In GRANT the memory ready is passed straight back to the grantee. On the
    // handshake the arbiter returns to IDLE and the round-robin pointer moves
    // to the index just past the grantee.
    always_comb begin
        state_d     = state_q;
        rrPtr_d     = rrPtr_q;
        grantId_d   = grantId_q;
        grantCfg_d  = grantCfg_q;
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    state_d    = GRANT;
                    grantId_d  = pickIdx;
                    grantCfg_d = req_qos_i[pickIdx];
                end
            end
            GRANT: begin
                req_ready_o[grantId_q] = mem_req_ready_i;
                if (mem_req_ready_i) begin
                    state_d = IDLE;
                    rrPtr_d = (grantId_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                                 : grantId_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-core wait counters. A counter restarts whenever its core is not
    // requesting or has just been accepted. Otherwise it counts up and sticks
    // at all-ones, so very long waits stay "late" and never wrap back to
    // looking fresh.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid_i[i] || (handshake && (grantId_q == IDX_W'(i)))) begin
                waitCnt_d[i] = '0;
            end else if (waitCnt_q[i] != '1) begin
                waitCnt_d[i] = waitCnt_q[i] + WAIT_W'(1);
            end else begin
                waitCnt_d[i] = waitCnt_q[i];
            end
        end
    end

    // Deadline-miss accounting. The grantee's wait count is compared before
    // the handshake clears it, against the budget latched at grant time. A
    // handshake that lands exactly on the budget is not counted as a miss.
    always_comb begin
        lateGrant = handshake && qos_enable_i && (grantLat != '0)
                 && (waitCnt_q[grantId_q] > grantLat);
        missCnt_d = missCnt_q;
        if (lateGrant && (missCnt_q != '1)) begin
            missCnt_d = missCnt_q + CNT_W'(1);
        end
    end

    // All state registers. Reset clears everything, including a grant that is
    // in flight, so the next arbitration starts again from requester 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            grantId_q  <= '0;
            grantCfg_q <= '0;
            missCnt_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                waitCnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rrPtr_q    <= rrPtr_d;
            grantId_q  <= grantId_d;
            grantCfg_q <= grantCfg_d;
            missCnt_q  <= missCnt_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                waitCnt_q[i] <= waitCnt_d[i];
            end
        end
    end

    assign mem_req_valid_o      = (state_q == GRANT);
    assign granted_valid_o      = (state_q == GRANT);
    assign grant_id_o           = grantId_q;
    assign granted_qos_config_o = grantCfg_q;
    assign deadline_miss_o      = missCnt_q;

    // Requesters must keep valid and config steady until they see ready.
    // A waiting request that drops or changes its config is a bug in the core.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_holdCheck
        a_reqHold: assert property (@(posedge clk_i) disable iff (rst_i)
            (req_valid_i[g] && !req_ready_o[g]) |=>
                (req_valid_i[g] && $stable(req_qos_i[g])));
    end

endmodule

// File: tb/tb_qos_arbiter.sv
// ---------------------------------------------------------------------------
// tb_qos_arbiter
//
// Self-checking bench for qos_arbiter. A behavioural reference model ranks
// requesters by a single priority key, (urgent, level), and scans the cores
// in rotated order to break ties. The model is compared with the DUT every
// cycle. The bench also holds a table of hand-derived vectors and a few
// directed multi-cycle scenarios.
// ---------------------------------------------------------------------------
module tb_qos_arbiter;
    import qos_pkg::*;

    localparam int N  = 4;
    localparam int IW = $clog2(N);
    localparam int WW = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          qen;
    logic          memReady;
    logic [N-1:0]  reqValid;
    qos_config_t   reqQos [N];
    logic [N-1:0]  reqReady;
    logic          memValid;
    logic          grantedValid;
    logic [IW-1:0] grantId;
    qos_config_t   grantedCfg;
    logic [CW-1:0] missCount;

    int checks   = 0;
    int failures = 0;
    int cycleNo  = 0;

    // Reference model state
    bit            modelLive = 1'b0;
    bit            mBusy;
    int            mGid;
    qos_config_t   mCfg;
    int            mPtr;
    int            mWait [N];
    longint        mMiss;
    bit [N-1:0]    lastAccepted;

    int            grantLog[$];
    int            grantCycle[$];

    typedef struct {
        logic          rst;
        logic [N-1:0]  valid;
        logic          ready;
        logic          expMemValid;
        logic [N-1:0]  expReady;
        logic [IW-1:0] expGid;
        logic [CW-1:0] expMiss;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    qos_arbiter #(
        .NUM_REQ (N),
        .WAIT_W  (WW),
        .CNT_W   (CW)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .qos_enable_i         (qen),
        .req_valid_i          (reqValid),
        .req_ready_o          (reqReady),
        .req_qos_i            (reqQos),
        .mem_req_valid_o      (memValid),
        .mem_req_ready_i      (memReady),
        .grant_id_o           (grantId),
        .granted_qos_config_o (grantedCfg),
        .granted_valid_o      (grantedValid),
        .deadline_miss_o      (missCount)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)",
                     name, actual, expected, cycleNo);
        end
    endtask

    function automatic bit isUrgent(input int i);
        int lat;
        lat = int'(reqQos[i].max_latency_cycles);
        return qen && reqValid[i] && (lat != 0) && (mWait[i] >= lat);
    endfunction

    // Highest key wins. Urgency adds 16, which beats any level. Scanning from
    // the pointer with a strict '>' keeps the earliest core on ties.
    function automatic int modelPick();
        int best;
        int bestKey;
        best    = -1;
        bestKey = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            int key;
            i = (mPtr + k) % N;
            if (reqValid[i]) begin
                key = (isUrgent(i) ? 16 : 0) + (qen ? int'(reqQos[i].qos_level) : 0);
                if (key > bestKey) begin
                    bestKey = key;
                    best    = i;
                end
            end
        end
        return best;
    endfunction

    // One clock cycle: check outputs against the model, advance the model with
    // the inputs currently driven, then step to the next falling edge.
    task automatic applyStimulus();
        bit           hs;
        int           oldGid;
        int           pick;
        int           lat;
        logic [N-1:0] expReady;
        #1;
        if (modelLive) begin
            expReady = (mBusy && memReady) ? (N'(1) << mGid) : '0;
            checkOutput("mem_req_valid", 64'(memValid), 64'(mBusy));
            checkOutput("granted_valid", 64'(grantedValid), 64'(mBusy));
            checkOutput("req_ready", 64'(reqReady), 64'(expReady));
            checkOutput("grant_id", 64'(grantId), 64'(mGid));
            checkOutput("granted_cfg", 64'(grantedCfg), 64'(mCfg));
            checkOutput("deadline_miss", 64'(missCount), 64'(mMiss));
        end
        if (memValid === 1'b1 && memReady === 1'b1) begin
            grantLog.push_back(int'(grantId));
            grantCycle.push_back(cycleNo);
        end
        if (rst) begin
            mBusy        = 1'b0;
            mGid         = 0;
            mCfg         = '0;
            mPtr         = 0;
            mMiss        = 0;
            lastAccepted = '0;
            for (int i = 0; i < N; i++) mWait[i] = 0;
        end else if (modelLive) begin
            hs     = mBusy && memReady;
            oldGid = mGid;
            lat    = int'(mCfg.max_latency_cycles);
            if (hs && qen && lat != 0 && mWait[oldGid] > lat && mMiss < 64'hFFFF_FFFF)
                mMiss++;
            if (!mBusy) begin
                pick = modelPick();
                if (pick >= 0) begin
                    mBusy = 1'b1;
                    mGid  = pick;
                    mCfg  = reqQos[pick];
                end
            end else if (hs) begin
                mBusy = 1'b0;
                mPtr  = (oldGid + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (!reqValid[i] || (hs && oldGid == i)) mWait[i] = 0;
                else if (mWait[i] < 65535) mWait[i] = mWait[i] + 1;
            end
            lastAccepted = hs ? (N'(1) << oldGid) : '0;
        end
        @(posedge clk);
        if (rst) modelLive = 1'b1;
        cycleNo++;
        @(negedge clk);
    endtask

    task automatic resetDut();
        rst      = 1'b1;
        reqValid = '0;
        applyStimulus();
        rst = 1'b0;
        grantLog.delete();
        grantCycle.delete();
    endtask

    function automatic int logAt(input int k);
        return (k < grantLog.size()) ? grantLog[k] : -1;
    endfunction

    function automatic int gapAt(input int k);
        return (k < grantCycle.size()) ? grantCycle[k] - grantCycle[k-1] : -1;
    endfunction

    // Random traffic that respects the hold-until-ready protocol. An accepted
    // core may drop its request or re-request with a fresh config.
    task automatic randomInputs();
        for (int i = 0; i < N; i++) begin
            if (reqValid[i] && !lastAccepted[i]) begin
                reqValid[i] = 1'b1;
            end else if (reqValid[i] && $urandom_range(0, 1) == 0) begin
                reqValid[i] = 1'b0;
            end else if (reqValid[i] || $urandom_range(0, 2) == 0) begin
                reqValid[i]                  = 1'b1;
                reqQos[i].qos_level          = 4'($urandom_range(0, 3));
                reqQos[i].max_latency_cycles = 16'($urandom_range(0, 8));
            end
        end
        memReady = ($urandom_range(0, 9) < 6);
        if ($urandom_range(0, 49) == 0) qen = ~qen;
        rst = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        int expOrder [5];
        expOrder = '{0, 1, 2, 3, 0};

        rst      = 1'b1;
        qen      = 1'b1;
        memReady = 1'b1;
        reqValid = '0;
        for (int i = 0; i < N; i++) reqQos[i] = '{qos_level: 4'd2, max_latency_cycles: 16'd0};
        applyStimulus();
        rst = 1'b0;

        // Table: single request, a stalled grant, mid-GRANT reset, then
        // round-robin restarting at requester 0.
        vecs[0]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 32'd0};
        vecs[1]  = '{1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 32'd0};
        vecs[2]  = '{1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 32'd0};
        vecs[3]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 32'd0};
        vecs[4]  = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'd0, 32'd0};
        vecs[5]  = '{1'b0, 4'b1000, 1'b0, 1'b1, 4'b0000, 2'd3, 32'd0};
        vecs[6]  = '{1'b1, 4'b1000, 1'b0, 1'b1, 4'b0000, 2'd3, 32'd0};
        vecs[7]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 32'd0};
        vecs[8]  = '{1'b0, 4'b0101, 1'b1, 1'b0, 4'b0000, 2'd0, 32'd0};
        vecs[9]  = '{1'b0, 4'b0101, 1'b1, 1'b1, 4'b0001, 2'd0, 32'd0};
        vecs[10] = '{1'b0, 4'b0101, 1'b1, 1'b0, 4'b0000, 2'd0, 32'd0};
        vecs[11] = '{1'b0, 4'b0101, 1'b1, 1'b1, 4'b0100, 2'd2, 32'd0};
        $display("[TB] table vectors");
        for (int v = 0; v < 12; v++) begin
            rst      = vecs[v].rst;
            reqValid = vecs[v].valid;
            memReady = vecs[v].ready;
            #1;
            checkOutput("tbl_mem_valid", 64'(memValid), 64'(vecs[v].expMemValid));
            checkOutput("tbl_req_ready", 64'(reqReady), 64'(vecs[v].expReady));
            checkOutput("tbl_grant_id", 64'(grantId), 64'(vecs[v].expGid));
            checkOutput("tbl_miss", 64'(missCount), 64'(vecs[v].expMiss));
            applyStimulus();
        end
        rst = 1'b0;

        // All four cores requesting at equal level: strict rotation, 2 cycles apart
        $display("[TB] equal-level rotation");
        resetDut();
        reqValid = '1;
        memReady = 1'b1;
        repeat (10) applyStimulus();
        for (int k = 0; k < 5; k++) checkOutput("rr_order", 64'(logAt(k)), 64'(expOrder[k]));
        for (int k = 1; k < 5; k++) checkOutput("rr_spacing", 64'(gapAt(k)), 64'd2);

        // Level 7 beats level 3 until the level-3 core turns urgent
        $display("[TB] urgency overrides level");
        reqValid = '0;
        for (int i = 0; i < N; i++) reqQos[i] = '0;
        resetDut();
        reqQos[1] = '{qos_level: 4'd7, max_latency_cycles: 16'd0};
        reqQos[2] = '{qos_level: 4'd3, max_latency_cycles: 16'd3};
        reqValid  = 4'b0110;
        repeat (6) applyStimulus();
        checkOutput("urg_first", 64'(logAt(0)), 64'd1);
        checkOutput("urg_second", 64'(logAt(1)), 64'd1);
        checkOutput("urg_third", 64'(logAt(2)), 64'd2);
        checkOutput("urg_miss", 64'(missCount), 64'd1);

        // Stalled memory pushes core 0 past its budget
        $display("[TB] stalled grant deadline miss");
        reqValid = '0;
        resetDut();
        reqQos[0] = '{qos_level: 4'd1, max_latency_cycles: 16'd2};
        reqValid  = 4'b0001;
        memReady  = 1'b0;
        repeat (6) applyStimulus();
        checkOutput("stall_miss_before", 64'(missCount), 64'd0);
        checkOutput("stall_cfg_held", 64'(grantedCfg), 64'({4'd1, 16'd2}));
        memReady = 1'b1;
        applyStimulus();
        reqValid = '0;
        checkOutput("stall_miss_after", 64'(missCount), 64'd1);

        // Plain round-robin ignores level and deadlines
        $display("[TB] qos disabled");
        resetDut();
        qen       = 1'b0;
        reqQos[0] = '{qos_level: 4'd0, max_latency_cycles: 16'd0};
        reqQos[3] = '{qos_level: 4'd15, max_latency_cycles: 16'd1};
        reqValid  = 4'b1001;
        memReady  = 1'b1;
        repeat (6) applyStimulus();
        checkOutput("rr_only_first", 64'(logAt(0)), 64'd0);
        checkOutput("rr_only_second", 64'(logAt(1)), 64'd3);
        checkOutput("rr_only_miss", 64'(missCount), 64'd0);
        reqValid = '0;
        qen      = 1'b1;

        // Random traffic against the reference model
        $display("[TB] random traffic");
        resetDut();
        repeat (3000) begin
            randomInputs();
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qos_arbiter.md
Name: qos_arbiter

Overview:
- Shares the single external memory request port between NUM_REQ cores.
- Arbitration is QoS-aware: deadline urgency first, then QoS level, then round-robin.
- Drives the granted requester's QoS config and valid to the downstream QoS monitor.
- Counts latency-deadline misses.
- Control-only: address/data muxing is done outside using grant_id_o.

Parameters:
- NUM_REQ, 4: number of requesting cores (2..8).
- WAIT_W, 16: width of each per-requester wait counter; saturating.
- CNT_W, 32: width of the deadline-miss counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- qos_enable_i  in  1  1 = QoS arbitration; 0 = plain round-robin.
- req_valid_i  in  NUM_REQ  per-core request valid.
- req_ready_o  out  NUM_REQ  per-core accept; one-hot or zero.
- req_qos_i  in  NUM_REQ x qos_config_t  per-core QoS config.
- mem_req_valid_o  out  1  request valid to memory.
- mem_req_ready_i  in  1  memory accept.
- grant_id_o  out  $clog2(NUM_REQ)  index of the current grantee.
- granted_qos_config_o  out  qos_config_t  config of the current grantee.
- granted_valid_o  out  1  granted_qos_config_o is valid; equals mem_req_valid_o.
- deadline_miss_o  out  CNT_W  count of deadline misses; saturating.

Behaviour:
- Reset: all of the following clear to 0 on the first clock edge with rst_i=1, including mid-transaction:
  - every output;
  - state = IDLE;
  - rr_ptr, all wait counters, the miss counter.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req_valid_i is set, select a winner and register grant_id and granted config; go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - mem_req_valid_o = granted_valid_o = 1.
  - req_ready_o[grant_id] = mem_req_ready_i (combinational); all other bits 0.
  - On handshake (mem_req_valid_o & mem_req_ready_i): rr_ptr <= (grant_id+1) mod NUM_REQ; return to IDLE.
- Latency:
  - Request first valid in cycle N with the arbiter in IDLE → mem_req_valid_o high in N+1.
  - One IDLE bubble cycle follows every handshake.
  - Maximum throughput is one grant per 2 cycles.
- Protocol rules:
  - A requester must hold req_valid_i and req_qos_i stable until its ready. Assertion required.
  - Config is registered at grant; changes after grant are ignored.
- Wait counters, per requester i:
  - Clear when req_valid_i[i]=0 or on handshake of i.
  - Otherwise increment by 1, saturating at 2^WAIT_W-1.
- urgent[i] = qos_enable_i & req_valid_i[i] & (max_latency_cycles != 0) & (wait[i] >= max_latency_cycles). max_latency_cycles is truncated/zero-extended to WAIT_W.
- Selection, combinational and used only in IDLE:
  - Candidates = urgent requesters if any; otherwise all valid requesters.
  - If qos_enable_i: keep only candidates with the maximum qos_level.
  - Pick the first remaining index at or after rr_ptr, wrapping modulo NUM_REQ.
  - If qos_enable_i=0: pure round-robin over valid requesters.
- Deadline miss:
  - On handshake, if qos_enable_i, granted max_latency_cycles != 0, and wait[grant_id] > max_latency_cycles → deadline_miss_o += 1.
  - Saturates at all-ones.
  - Compare is on wait[grant_id] before it clears in the same edge.
- Simultaneous events:
  - A handshake and a new request from the same core in the same cycle: the new request is arbitrated in the next IDLE cycle and its wait counter starts from 0.
  - Toggling qos_enable_i takes effect on the next selection; a grant already in GRANT is unaffected.

Decomposition:
- qos_pkg holds:
  - qos_config_t, which contains at least qos_level[3:0] and max_latency_cycles[15:0];
  - the arb_state_e enum (IDLE, GRANT);
  - the QOS_MAX_REQ=8 constant.
- One sub-module: qos_rr_select, a combinational masked round-robin picker. It takes a candidate vector and rr_ptr and returns the chosen index plus a found flag.
- Wait counters and the FSM stay in qos_arbiter.

Test Plan:
- Single core 0 request, mem_req_ready_i=1, qos_enable_i=1:
  - mem_req_valid_o rises 1 cycle after req_valid_i[0];
  - req_ready_o=0001 in that cycle;
  - grant_id_o=0; deadline_miss_o stays 0.
- All 4 cores valid continuously, equal qos_level=2, ready=1:
  - grants in order 0,1,2,3,0;
  - each grant 2 cycles apart.
- Cores 1 (level 7) and 2 (level 3) valid, core 2 with max_latency_cycles=3, ready=1:
  - core 1 granted first;
  - core 2 becomes urgent when wait reaches 3 and beats a re-requesting core 1 at level 7.
- Core 0 with max_latency_cycles=2, memory ready held low 5 cycles:
  - handshake occurs with wait>2;
  - deadline_miss_o increments 0→1;
  - granted_qos_config_o stable throughout GRANT.
- qos_enable_i=0, core 3 level 15, core 0 level 0, rr_ptr=0:
  - core 0 granted first (level ignored);
  - deadline_miss_o unchanged.
- Assert rst_i mid-GRANT:
  - next cycle mem_req_valid_o=0, req_ready_o=0, deadline_miss_o=0;
  - the next arbitration starts from rr_ptr=0.
